// File: rtl/fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_reader_pkg
// Shared types and sizing helpers for the fifo_pop_reader block.
//   state_t     : reader FSM states (IDLE, RUN, FLUSH)
//   drop_cnt_w  : width of the flush drop counter for a given FIFO depth
//                 (one bit of headroom over the depth so a full FIFO fits)
// -----------------------------------------------------------------------------
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int drop_cnt_w(input int depth);
        return $clog2(depth + 1) + 1;
    endfunction

    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_DROP_W = drop_cnt_w(DEFAULT_DEPTH);

endpackage

// File: rtl/fifo_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry in-order valid/ready buffer. Entry 0 is the head and drives the
// registered output directly; entry 1 is the skid slot used while the
// downstream stalls.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   wr, din    : write strobe and data (caller never writes when full unless a
//                read completes in the same cycle)
//   rd_ready   : downstream ready
//   dout, valid: registered head word and its valid
//   occ        : occupancy 0..2
// -----------------------------------------------------------------------------
module fifo_skid_buf #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [width-1:0] din,
    input  logic             rd_ready,
    output logic [width-1:0] dout,
    output logic             valid,
    output logic [1:0]       occ
);

    logic [width-1:0] d1;
    logic             v1;
    logic             rd;

    assign rd  = valid && rd_ready;
    // Entry 1 is only ever valid behind a valid entry 0.
    assign occ = {v1, valid & ~v1};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            v1    <= 1'b0;
            dout  <= '0;
            // NOTE: the skid slot holds no observable value while v1=0; it is
            // cleared anyway so the whole buffer shares one reset branch.
            d1    <= '0;
        end else if (rd) begin
            if (v1) begin
                dout <= d1;
                if (wr) d1 <= din;   // shift and refill: occupancy stays 2
                else    v1 <= 1'b0;
            end else begin
                if (wr) dout  <= din; // pass-through: occupancy stays 1
                else    valid <= 1'b0;
            end
        end else if (wr) begin
            if (!valid) begin
                dout  <= din;
                valid <= 1'b1;
            end else begin
                d1 <= din;
                v1 <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_pop_reader.sv
// -----------------------------------------------------------------------------
// fifo_pop_reader
// Consumer-side engine for the flop FIFO: pops words while the FIFO is
// non-empty and the skid buffer has room, and presents them on a registered
// valid/ready stream. A flush request drains the FIFO and discards its words,
// counting the discards.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   fifo_dout, fifo_pndng  : FIFO head word and non-empty flag
//   fifo_pop               : combinational pop strobe to the FIFO
//   out_data, out_valid    : registered downstream stream
//   out_ready              : downstream ready
//   out_parity             : even parity of out_data (FIFO_READER_PARITY_EN only)
//   flush                  : one-cycle drain request (ignored while flushing)
//   flush_busy             : high while flushing
//   flush_drops            : words discarded by the last flush, saturating
// Optional feature macro: FIFO_READER_PARITY_EN
// -----------------------------------------------------------------------------
module fifo_pop_reader
    import fifo_reader_pkg::*;
#(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [width-1:0]             fifo_dout,
    input  logic                         fifo_pndng,
    output logic                         fifo_pop,
    output logic [width-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef FIFO_READER_PARITY_EN
    output logic                         out_parity,
`endif
    input  logic                         flush,
    output logic                         flush_busy,
    output logic [drop_cnt_w(depth)-1:0] flush_drops
);

    localparam int               drop_w   = drop_cnt_w(depth);
    localparam logic [drop_w-1:0] drop_max = '1;

`ifdef FIFO_READER_PARITY_EN
    // Parity travels through the buffer as an extra bit so it stays aligned
    // with its word.
    localparam int buf_w = width + 1;
`else
    localparam int buf_w = width;
`endif

    state_t           state;
    state_t           state_next;
    logic [1:0]       occ;
    logic             beat;
    logic             run_pop;
    logic             drain_pop;
    logic [buf_w-1:0] buf_din;
    logic [buf_w-1:0] buf_dout;

    assign beat = out_valid && out_ready;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        run_pop   = 1'b0;
        drain_pop = 1'b0;
        case (state)
            // Room exists when not full, or when full but the head leaves now.
            // A flush request suppresses the pop in its own cycle.
            RUN:     run_pop   = fifo_pndng && !flush && (occ != 2'd2 || beat);
            // Discard only once every buffered word has been delivered.
            FLUSH:   drain_pop = fifo_pndng && (occ == 2'd0);
            default: ;
        endcase
    end

    assign fifo_pop   = run_pop || drain_pop;
    assign flush_busy = (state == FLUSH);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (flush) state_next = FLUSH;
            FLUSH:   if (occ == 2'd0 && !fifo_pndng) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flush_drops <= '0;
        end else begin
            state <= state_next;
            if (state == RUN && flush)
                flush_drops <= '0;
            else if (drain_pop && flush_drops != drop_max)
                flush_drops <= flush_drops + drop_w'(1);
        end
    end

`ifdef FIFO_READER_PARITY_EN
    assign buf_din    = {^fifo_dout, fifo_dout};
    assign out_data   = buf_dout[width-1:0];
    assign out_parity = buf_dout[width];
`else
    assign buf_din    = fifo_dout;
    assign out_data   = buf_dout;
`endif

    fifo_skid_buf #(
        .width (buf_w)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .wr       (run_pop),
        .din      (buf_din),
        .rd_ready (out_ready),
        .dout     (buf_dout),
        .valid    (out_valid),
        .occ      (occ)
    );

endmodule
